// File: rtl/sar_result_reader.sv
// Captures SAR conversion results on the rising edge of EOC, buffers them in a
// first-word-fall-through FIFO and streams them out; also gates the SAR controller reset.
module sar_result_reader #(
  parameter int DEPTH         = 4,
  parameter int STALL_ON_FULL = 1,
  parameter int CNT_W         = 16
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic                     ENABLE,
  input  logic                     EOC,
  input  logic [0:9]               DIN,
  output logic                     ADC_RST,
  output logic [9:0]               M_DATA,
  output logic                     M_VALID,
  input  logic                     M_READY,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     OVF,
  input  logic                     CLR_OVF,
  output logic [CNT_W-1:0]         SAMPLE_CNT
);

  localparam int   PW    = $clog2(DEPTH);
  localparam int   LW    = PW + 1;
  localparam logic STALL = (STALL_ON_FULL != 0);

  logic          eoc_q;
  logic          cap_pend;
  logic          rise;
  logic [9:0]    wdata;
  logic [9:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [LW-1:0] level;
  logic [LW-1:0] level_next;
  logic [9:0]    head;
  logic [9:0]    head_next;
  logic          push;
  logic          pop;
  logic          full;
  logic          full_next;
  logic          push_ok;
  logic          drop;

  assign rise = EOC & ~eoc_q & ENABLE;
  assign push = cap_pend;

  // Stream handshake: a result transfers on every clock edge where M_VALID and
  // M_READY are both high; M_VALID never depends on M_READY.
  assign pop       = M_VALID & M_READY;
  assign full      = (level == LW'(DEPTH));
  assign push_ok   = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign level_next = level + LW'(push_ok) - LW'(pop);
  assign full_next = (level_next == LW'(DEPTH));

  assign M_VALID = (level != '0);
  assign M_DATA  = head;
  assign LEVEL   = level;

  always_comb begin
    wdata = '0;
    for (int i = 0; i < 10; i++) begin
      wdata[9-i] = DIN[i];
    end
  end

  // Head register tracks the entry that will be at the read pointer after this edge.
  always_comb begin
    head_next = head;
    if (pop) begin
      if (level > LW'(1)) begin
        head_next = mem[rd_ptr + PW'(1)];
      end else if (push_ok) begin
        head_next = wdata;
      end
    end else if ((level == '0) && push_ok) begin
      head_next = wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      eoc_q      <= 1'b0;
      cap_pend   <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      head       <= '0;
      OVF        <= 1'b0;
      SAMPLE_CNT <= '0;
      ADC_RST    <= 1'b1;
    end else begin
      eoc_q    <= EOC;
      // A persistent EOC cannot re-trigger, so the capture always lands one edge after the rise.
      cap_pend <= rise;
      level    <= level_next;
      head     <= head_next;
      if (push_ok) begin
        wr_ptr     <= wr_ptr + PW'(1);
        SAMPLE_CNT <= SAMPLE_CNT + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (drop) begin
        OVF <= 1'b1;
      end else if (CLR_OVF) begin
        OVF <= 1'b0;
      end
      ADC_RST <= ~ENABLE | (STALL & full_next);
    end
  end

endmodule

// File: tb/tb_sar_result_reader.sv
// Bench for sar_result_reader: a stalling instance (a_*) and a dropping instance
// with a 3-bit sample counter (b_*), table-driven captures plus stream scoreboards.
module tb_sar_result_reader;

  logic       CLK;
  logic       RSTN;

  logic       a_en, a_eoc, a_rdy, a_clr;
  logic [0:9] a_din;
  logic       a_adc_rst, a_valid, a_ovf;
  logic [9:0] a_data;
  logic [2:0] a_level;
  logic [15:0] a_cnt;

  logic       b_en, b_eoc, b_rdy, b_clr;
  logic [0:9] b_din;
  logic       b_adc_rst, b_valid, b_ovf;
  logic [9:0] b_data;
  logic [2:0] b_level;
  logic [2:0] b_cnt;

  int errors = 0;
  int checks = 0;

  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];

  typedef struct {
    logic [9:0] din;
    logic [9:0] exp_data;
  } vec_t;
  vec_t tbl[5];

  sar_result_reader #(.DEPTH(4), .STALL_ON_FULL(1), .CNT_W(16)) dut_a (
    .CLK(CLK), .RSTN(RSTN), .ENABLE(a_en), .EOC(a_eoc), .DIN(a_din),
    .ADC_RST(a_adc_rst), .M_DATA(a_data), .M_VALID(a_valid), .M_READY(a_rdy),
    .LEVEL(a_level), .OVF(a_ovf), .CLR_OVF(a_clr), .SAMPLE_CNT(a_cnt)
  );

  sar_result_reader #(.DEPTH(4), .STALL_ON_FULL(0), .CNT_W(3)) dut_b (
    .CLK(CLK), .RSTN(RSTN), .ENABLE(b_en), .EOC(b_eoc), .DIN(b_din),
    .ADC_RST(b_adc_rst), .M_DATA(b_data), .M_VALID(b_valid), .M_READY(b_rdy),
    .LEVEL(b_level), .OVF(b_ovf), .CLR_OVF(b_clr), .SAMPLE_CNT(b_cnt)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: one EOC pulse, result pushed on the following edge
  task automatic conv_a(input logic [9:0] d, input bit accepted);
    a_din = d;
    a_eoc = 1'b1;
    if (accepted) exp_a.push_back(d);
    tick();
    a_eoc = 1'b0;
    tick();
  endtask

  task automatic conv_b(input logic [9:0] d, input bit accepted);
    b_din = d;
    b_eoc = 1'b1;
    if (accepted) exp_b.push_back(d);
    tick();
    b_eoc = 1'b0;
    tick();
  endtask

  // scoreboard: compare every transferred result against the expected queue
  always @(negedge CLK) begin
    if (RSTN && a_valid && a_rdy) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL a_stream: got %0h expected nothing", a_data);
      end else begin
        logic [9:0] e;
        e = exp_a.pop_front();
        if (a_data !== e) begin
          errors++;
          $display("FAIL a_stream: got %0h expected %0h", a_data, e);
        end
      end
    end
    if (RSTN && b_valid && b_rdy) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL b_stream: got %0h expected nothing", b_data);
      end else begin
        logic [9:0] e;
        e = exp_b.pop_front();
        if (b_data !== e) begin
          errors++;
          $display("FAIL b_stream: got %0h expected %0h", b_data, e);
        end
      end
    end
  end

  initial begin
    logic [9:0] first_b;
    logic [9:0] d;

    tbl[0] = '{din: 10'b1000000001, exp_data: 10'h201};
    tbl[1] = '{din: 10'b1100000000, exp_data: 10'h300};
    tbl[2] = '{din: 10'b0000000011, exp_data: 10'h003};
    tbl[3] = '{din: 10'b0101010101, exp_data: 10'h155};
    tbl[4] = '{din: 10'b1111111111, exp_data: 10'h3FF};

    RSTN = 1'b1;
    a_en = 0; a_eoc = 0; a_rdy = 0; a_clr = 0; a_din = '0;
    b_en = 0; b_eoc = 0; b_rdy = 0; b_clr = 0; b_din = '0;
    #1 RSTN = 1'b0;
    #1;
    chk("rst_adc_rst", a_adc_rst, 1);
    chk("rst_valid", a_valid, 0);
    chk("rst_data", a_data, 0);
    chk("rst_level", a_level, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_cnt", a_cnt, 0);
    tick();
    tick();
    RSTN = 1'b1;
    tick();
    chk("adc_rst_disabled", a_adc_rst, 1);
    a_en = 1'b1;
    b_en = 1'b1;
    tick();
    chk("adc_rst_enabled", a_adc_rst, 0);

    // table-driven single conversions
    for (int i = 0; i < 5; i++) begin
      a_din = tbl[i].din;
      a_eoc = 1'b1;
      exp_a.push_back(tbl[i].exp_data);
      tick();
      chk("latency_valid", a_valid, 0);
      a_eoc = 1'b0;
      tick();
      chk("single_valid", a_valid, 1);
      chk("single_data", a_data, tbl[i].exp_data);
      chk("single_level", a_level, 1);
      chk("single_cnt", a_cnt, i + 1);
      a_rdy = 1'b1;
      tick();
      a_rdy = 1'b0;
      chk("pop_level", a_level, 0);
      chk("pop_valid", a_valid, 0);
      chk("data_hold", a_data, tbl[i].exp_data);
    end

    // EOC held high produces one capture
    a_din = 10'h0F0;
    a_eoc = 1'b1;
    exp_a.push_back(10'h0F0);
    repeat (20) tick();
    a_eoc = 1'b0;
    tick();
    chk("persist_cnt", a_cnt, 6);
    chk("persist_level", a_level, 1);
    a_rdy = 1'b1;
    tick();
    a_rdy = 1'b0;

    // ENABLE low masks the rise
    a_en = 1'b0;
    a_eoc = 1'b1;
    tick();
    a_eoc = 1'b0;
    tick();
    tick();
    chk("masked_cnt", a_cnt, 6);
    chk("masked_level", a_level, 0);
    chk("masked_adc_rst", a_adc_rst, 1);
    a_en = 1'b1;
    tick();
    chk("reenable_adc_rst", a_adc_rst, 0);

    // capture pending at disable still completes
    a_din = 10'h123;
    a_eoc = 1'b1;
    exp_a.push_back(10'h123);
    tick();
    a_en = 1'b0;
    a_eoc = 1'b0;
    tick();
    chk("pending_level", a_level, 1);
    chk("pending_adc_rst", a_adc_rst, 1);
    chk("pending_cnt", a_cnt, 7);
    a_en = 1'b1;
    tick();
    chk("pending_adc_rst_clear", a_adc_rst, 0);
    a_rdy = 1'b1;
    tick();
    a_rdy = 1'b0;

    // stall on full
    for (int j = 0; j < 4; j++) begin
      chk("stall_pre_adc_rst", a_adc_rst, 0);
      conv_a(10'($urandom_range(0, 1023)), 1'b1);
    end
    chk("stall_level", a_level, 4);
    chk("stall_adc_rst", a_adc_rst, 1);
    chk("stall_ovf", a_ovf, 0);
    chk("stall_cnt", a_cnt, 11);
    a_rdy = 1'b1;
    tick();
    a_rdy = 1'b0;
    chk("stall_pop_level", a_level, 3);
    chk("stall_pop_adc_rst", a_adc_rst, 0);
    a_rdy = 1'b1;
    repeat (3) tick();
    a_rdy = 1'b0;
    chk("stall_drain_level", a_level, 0);

    // overflow on the dropping instance
    first_b = 10'h2C5;
    conv_b(first_b, 1'b1);
    for (int j = 1; j < 5; j++) begin
      conv_b(10'($urandom_range(0, 1023)), j < 4);
    end
    chk("ovf_level", b_level, 4);
    chk("ovf_set", b_ovf, 1);
    chk("ovf_cnt", b_cnt, 4);
    chk("ovf_head", b_data, first_b);
    chk("ovf_no_stall", b_adc_rst, 0);
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    chk("ovf_clear", b_ovf, 0);

    // drop and clear on the same edge: set wins
    b_din = 10'h011;
    b_eoc = 1'b1;
    tick();
    b_eoc = 1'b0;
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    chk("ovf_set_wins", b_ovf, 1);
    chk("ovf_set_wins_cnt", b_cnt, 4);
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    chk("ovf_clear2", b_ovf, 0);

    // push and pop together while full
    d = 10'h3A7;
    b_din = d;
    b_eoc = 1'b1;
    exp_b.push_back(d);
    tick();
    b_eoc = 1'b0;
    b_rdy = 1'b1;
    tick();
    b_rdy = 1'b0;
    chk("pushpop_level", b_level, 4);
    chk("pushpop_ovf", b_ovf, 0);
    chk("pushpop_cnt", b_cnt, 5);
    b_rdy = 1'b1;
    repeat (4) tick();
    b_rdy = 1'b0;
    chk("pushpop_drain", b_level, 0);

    // counter wrap with a streaming consumer
    b_rdy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      conv_b(10'($urandom_range(0, 1023)), 1'b1);
    end
    chk("cnt_wrap", b_cnt, 0);
    tick();
    tick();
    b_rdy = 1'b0;
    chk("wrap_drain", b_level, 0);

    // reset mid-stream with two entries queued
    conv_a(10'h155, 1'b0);
    conv_a(10'h2AA, 1'b0);
    chk("pre_reset_level", a_level, 2);
    #2 RSTN = 1'b0;
    #1;
    chk("mid_rst_adc_rst", a_adc_rst, 1);
    chk("mid_rst_valid", a_valid, 0);
    chk("mid_rst_data", a_data, 0);
    chk("mid_rst_level", a_level, 0);
    chk("mid_rst_ovf", a_ovf, 0);
    chk("mid_rst_cnt", a_cnt, 0);
    tick();
    RSTN = 1'b1;
    chk("release_adc_rst", a_adc_rst, 1);
    tick();
    chk("release_adc_rst_en", a_adc_rst, 0);
    chk("release_level", a_level, 0);
    tick();
    chk("release_no_capture", a_cnt, 0);

    chk("exp_a_empty", exp_a.size(), 0);
    chk("exp_b_empty", exp_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
